// File: rtl/fetch_unit_if.sv
// Instruction-memory read port used by the fetch stage.
// The fetch unit is the master (drives request and address); the memory
// side is the slave (returns grant, read-valid and read data).
interface fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the multicycle RV32I core.
// Owns PC, OldPC and IR. On fetch_start it reads the word at PC over a
// req/gnt/rvalid handshake, loads IR/oldpc and pulses fetch_done for the
// control unit. Misaligned fetches and stalled reads raise sticky flags.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_start,
    input  logic               pcwrite,
    input  logic [31:0]        pc_next,
    fetch_unit_if.master       mem,
    output logic [31:0]        instr,
    output logic [31:0]        oldpc,
    output logic [31:0]        pc,
    output logic               busy,
    output logic               fetch_done,
    output logic               misaligned,
    output logic               timeout_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // The last WAIT cycle that may still accept rvalid is the TIMEOUT-th one,
    // i.e. when the counter (cleared on grant) reads TIMEOUT-1.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;

    // PC register: control may overwrite it in any state. The in-flight
    // address lives in mem_addr, so a PC change never disturbs a fetch.
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create ordering-dependent logic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (pcwrite) begin
            pc <= pc_next;
        end
    end

    // Fetch sequencer: IDLE -> REQ -> WAIT -> DONE -> IDLE, with registered
    // request, IR/oldpc loading, done pulse and sticky error flags.
    // NOTE: reset is synchronous, so it sits inside the clocked branch and
    // a late rvalid after reset is dropped simply because state is IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= 32'h0;
            instr        <= NOP;
            oldpc        <= 32'h0;
            fetch_done   <= 1'b0;
            misaligned   <= 1'b0;
            timeout_err  <= 1'b0;
            wait_cnt     <= 16'h0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        if (pc[1:0] == 2'b00) begin
                            mem.mem_req  <= 1'b1;
                            mem.mem_addr <= pc;
                            state        <= REQ;
                        end else begin
                            misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        wait_cnt    <= 16'h0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        instr      <= mem.mem_rdata;
                        oldpc      <= mem.mem_addr;
                        fetch_done <= 1'b1;
                        state      <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy is a pure decode of the state register.
    assign busy = (state != IDLE);

endmodule
